// File: rtl/vco_adc_decimator.sv
// ----------------------------------------------------------------------------
// vco_adc_decimator
//
// Upstream stage of the VCO-ADC sample FIFO. Each clock the synchronised VCO
// edge counter is differenced against its previous value (modulo counter
// width), giving the instantaneous frequency. The differences are summed over
// a programmable window (boxcar decimation). When a window closes, one tagged
// word {seq, sum} is pushed into the FIFO, or a sticky overflow flag is
// raised if the FIFO is full.
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst          asynchronous active-high reset
//   enable_i     run the decimator; low returns to IDLE, partial window lost
//   decim_i      samples per window; 0 and 1 are treated as 2
//   count_i      VCO edge counter (binary, already in clk domain)
//   fifo_full_i  FIFO full flag, checked on the closing cycle
//   clear_i      synchronous clear of the sticky flags (set wins)
//   write_o      one-cycle FIFO write strobe
//   data_o       {seq[7:0], sum[SUM_WIDTH-1:0]}
//   overflow_o   sticky: a window closed while the FIFO was full
//   sat_o        sticky: the accumulator clamped at full scale
//   busy_o       high while in PRIME or ACCUM
// ----------------------------------------------------------------------------
module vco_adc_decimator #(
    parameter int COUNT_WIDTH = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int SUM_WIDTH   = DATA_WIDTH - 8,
    parameter int DECIM_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic [DECIM_WIDTH-1:0] decim_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic                   fifo_full_i,
    input  logic                   clear_i,
    output logic                   write_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   overflow_o,
    output logic                   sat_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        ACCUM = 2'b10
    } state_t;

    localparam logic [DECIM_WIDTH-1:0] MIN_DECIM = DECIM_WIDTH'(2);
    localparam logic [DECIM_WIDTH-1:0] ONE_DECIM = DECIM_WIDTH'(1);
    localparam logic [SUM_WIDTH-1:0]   SUM_MAX   = {SUM_WIDTH{1'b1}};

    state_t                 state_r;
    logic [COUNT_WIDTH-1:0] prev_r;
    logic [SUM_WIDTH-1:0]   acc_r;
    logic [DECIM_WIDTH-1:0] cnt_r;
    logic [DECIM_WIDTH-1:0] decim_r;
    logic [7:0]             seq_r;

    logic [COUNT_WIDTH-1:0] diff_s;
    logic [SUM_WIDTH:0]     sum_ext_s;
    logic                   sat_hit_s;
    logic [SUM_WIDTH-1:0]   sum_s;
    logic                   last_s;
    logic [DECIM_WIDTH-1:0] decim_eff_s;
    logic                   accum_act_s;
    logic                   set_ovf_s;
    logic                   set_sat_s;

    // Datapath: modulo difference, saturating add and window-close detection.
    always_comb begin
        diff_s      = count_i - prev_r;
        // One extra bit catches the carry out; once acc sits at full scale any
        // nonzero diff carries again, so the clamp holds for the window.
        sum_ext_s   = {1'b0, acc_r} + (SUM_WIDTH + 1)'(diff_s);
        sat_hit_s   = sum_ext_s[SUM_WIDTH];
        if (sat_hit_s) begin
            sum_s = SUM_MAX;
        end else begin
            sum_s = sum_ext_s[SUM_WIDTH-1:0];
        end
        last_s      = (cnt_r == (decim_r - ONE_DECIM));
        if (decim_i < MIN_DECIM) begin
            decim_eff_s = MIN_DECIM;
        end else begin
            decim_eff_s = decim_i;
        end
        accum_act_s = enable_i && (state_r == ACCUM);
        set_ovf_s   = accum_act_s && last_s && fifo_full_i;
        set_sat_s   = accum_act_s && sat_hit_s;
    end

    // Control FSM with registered outputs and sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            prev_r     <= '0;
            acc_r      <= '0;
            cnt_r      <= '0;
            decim_r    <= MIN_DECIM;
            seq_r      <= 8'd0;
            write_o    <= 1'b0;
            data_o     <= '0;
            overflow_o <= 1'b0;
            sat_o      <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            write_o    <= 1'b0;
            // A set event in the same cycle as clear_i wins.
            overflow_o <= set_ovf_s | (overflow_o & ~clear_i);
            sat_o      <= set_sat_s | (sat_o & ~clear_i);
            if (!enable_i) begin
                state_r <= IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        decim_r <= decim_eff_s;
                        state_r <= PRIME;
                        busy_o  <= 1'b1;
                    end
                    PRIME: begin
                        prev_r  <= count_i;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= ACCUM;
                        busy_o  <= 1'b1;
                    end
                    ACCUM: begin
                        prev_r <= count_i;
                        busy_o <= 1'b1;
                        if (last_s) begin
                            acc_r <= '0;
                            cnt_r <= '0;
                            // seq advances on dropped windows too, so gaps show.
                            seq_r <= seq_r + 8'd1;
                            if (!fifo_full_i) begin
                                data_o  <= {seq_r, sum_s};
                                write_o <= 1'b1;
                            end else begin
                                data_o  <= data_o;
                            end
                        end else begin
                            acc_r <= sum_s;
                            cnt_r <= cnt_r + ONE_DECIM;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vco_adc_decimator.sv
// ----------------------------------------------------------------------------
// tb_vco_adc_decimator
//
// Directed, table-driven bench for vco_adc_decimator. The VCO counter is
// modelled as a ramp with a fixed step per clock, so every window sum is
// D*step (or full scale if it saturates). Hand-written sequences cover FIFO
// full, sticky-flag clearing, saturation, enable drop and reset mid-window.
// ----------------------------------------------------------------------------
module tb_vco_adc_decimator;

    logic        clk;
    logic        rst;
    logic        enable_i;
    logic [9:0]  decim_i;
    logic [15:0] count_i;
    logic        fifo_full_i;
    logic        clear_i;
    logic        write_o;
    logic [31:0] data_o;
    logic        overflow_o;
    logic        sat_o;
    logic        busy_o;

    vco_adc_decimator dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .decim_i     (decim_i),
        .count_i     (count_i),
        .fifo_full_i (fifo_full_i),
        .clear_i     (clear_i),
        .write_o     (write_o),
        .data_o      (data_o),
        .overflow_o  (overflow_o),
        .sat_o       (sat_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  decim;
        logic [15:0] start;
        logic [15:0] step;
        int          nwin;
        int          d_eff;
        logic [23:0] sum;
    } vec_t;

    vec_t        vecs [5];
    int          n_cmp;
    int          n_err;
    logic [15:0] step_v;
    logic [7:0]  seq_m;
    logic [31:0] old_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample point is 1 time unit after the edge, then the
    // counter ramp advances for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        count_i = count_i + step_v;
    endtask

    // Run 'lat' clocks; the last must carry a write of {seq_m, sum}.
    task automatic run_window(input int lat, input logic [23:0] sum, input string name);
        logic early;
        early = 1'b0;
        for (int k = 1; k < lat; k++) begin
            tick();
            if (write_o) early = 1'b1;
        end
        tick();
        check({name, " no early write"}, {31'd0, early}, 32'd0);
        check({name, " write_o"}, {31'd0, write_o}, 32'd1);
        check({name, " data_o"}, data_o, {seq_m, sum});
        seq_m = seq_m + 8'd1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        seq_m = 8'd0;
        step_v = 16'd0;
        rst = 1'b1;
        enable_i = 1'b0;
        decim_i = 10'd4;
        count_i = 16'd0;
        fifo_full_i = 1'b0;
        clear_i = 1'b0;

        vecs[0] = '{decim: 10'd4, start: 16'h0000, step: 16'd5,     nwin: 3, d_eff: 4, sum: 24'h000014};
        vecs[1] = '{decim: 10'd4, start: 16'hFFFE, step: 16'd3,     nwin: 3, d_eff: 4, sum: 24'h00000C};
        vecs[2] = '{decim: 10'd0, start: 16'h0000, step: 16'd7,     nwin: 2, d_eff: 2, sum: 24'h00000E};
        vecs[3] = '{decim: 10'd1, start: 16'd100,  step: 16'd1,     nwin: 2, d_eff: 2, sum: 24'h000002};
        vecs[4] = '{decim: 10'd8, start: 16'h1234, step: 16'h0100, nwin: 2, d_eff: 8, sum: 24'h000800};

        // Reset state
        tick();
        tick();
        check("reset write_o", {31'd0, write_o}, 32'd0);
        check("reset data_o", data_o, 32'd0);
        check("reset flags", {29'd0, overflow_o, sat_o, busy_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven windows; seq carries across enable cycles.
        for (int v = 0; v < 5; v++) begin
            decim_i  = vecs[v].decim;
            count_i  = vecs[v].start;
            step_v   = vecs[v].step;
            enable_i = 1'b1;
            run_window(vecs[v].d_eff + 2, vecs[v].sum, $sformatf("vec%0d win0", v));
            for (int w = 1; w < vecs[v].nwin; w++) begin
                run_window(vecs[v].d_eff, vecs[v].sum, $sformatf("vec%0d win%0d", v, w));
            end
            enable_i = 1'b0;
            tick();
            tick();
            check($sformatf("vec%0d idle busy", v), {31'd0, busy_o}, 32'd0);
            check($sformatf("vec%0d idle write", v), {31'd0, write_o}, 32'd0);
        end
        check("no sat yet", {31'd0, sat_o}, 32'd0);

        // Saturation: D=1023, diff=0xFFFF every cycle
        decim_i  = 10'h3FF;
        count_i  = 16'h0000;
        step_v   = 16'hFFFF;
        enable_i = 1'b1;
        run_window(1025, 24'hFFFFFF, "sat");
        check("sat_o set", {31'd0, sat_o}, 32'd1);
        enable_i = 1'b0;
        clear_i  = 1'b1;
        tick();
        clear_i  = 1'b0;
        check("sat_o cleared", {31'd0, sat_o}, 32'd0);
        tick();

        // Enable dropped at cnt=2 of D=4, then re-enabled
        decim_i  = 10'd4;
        step_v   = 16'd5;
        enable_i = 1'b1;
        tick();
        check("prime busy", {31'd0, busy_o}, 32'd1);
        tick();
        tick();
        tick();
        enable_i = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (write_o) seen = 1'b1;
            end
            check("drop no write", {31'd0, seen}, 32'd0);
        end
        enable_i = 1'b1;
        run_window(6, 24'h000014, "reenable");

        // FIFO full on the second closing cycle
        run_window(4, 24'h000014, "pre-full");
        old_data = data_o;
        tick();
        tick();
        tick();
        fifo_full_i = 1'b1;
        tick();
        fifo_full_i = 1'b0;
        check("full write_o", {31'd0, write_o}, 32'd0);
        check("full overflow", {31'd0, overflow_o}, 32'd1);
        check("full data hold", data_o, old_data);
        seq_m = seq_m + 8'd1;
        run_window(4, 24'h000014, "post-full");
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("overflow cleared", {31'd0, overflow_o}, 32'd0);
        tick();
        tick();
        fifo_full_i = 1'b1;
        clear_i     = 1'b1;
        tick();
        fifo_full_i = 1'b0;
        clear_i     = 1'b0;
        check("set wins over clear", {31'd0, overflow_o}, 32'd1);
        seq_m = seq_m + 8'd1;

        // Reset mid-window
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async rst write", {31'd0, write_o}, 32'd0);
        check("async rst data", data_o, 32'd0);
        check("async rst flags", {29'd0, overflow_o, sat_o, busy_o}, 32'd0);
        tick();
        rst = 1'b0;
        seq_m = 8'd0;
        run_window(6, 24'h000014, "after rst");
        enable_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
